// File: rtl/bcd_stopwatch.sv
// Minutes/seconds BCD stopwatch counting rising edges of a 1 Hz tick, with start/stop/pause, clear and wrap.
// Optional lap hold is enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       resetSW,
  input  logic       tickIn,
  input  logic       startStop,
  input  logic       clear,
  input  logic       lapBtn,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic [3:0] minTens,
  output logic       running,
  output logic       wrapPulse
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic       tick_prev_r, ss_prev_r;
  logic       tick_edge_s, ss_edge_s;
  logic [3:0] sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
  logic [3:0] sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic       wrap_s, running_r, wrap_r;

  assign tick_edge_s = tickIn & ~tick_prev_r;
  assign ss_edge_s   = startStop & ~ss_prev_r;

  // Next state and next count: clear beats startStop, which beats the tick.
  always_comb begin
    state_s    = state_r;
    sec_ones_s = sec_ones_r;
    sec_tens_s = sec_tens_r;
    min_ones_s = min_ones_r;
    min_tens_s = min_tens_r;
    wrap_s     = 1'b0;
    if (clear) begin
      state_s    = ST_IDLE;
      sec_ones_s = 4'd0;
      sec_tens_s = 4'd0;
      min_ones_s = 4'd0;
      min_tens_s = 4'd0;
    end else if (ss_edge_s) begin
      case (state_r)
        ST_IDLE:  state_s = ST_RUN;
        ST_RUN:   state_s = ST_PAUSE;
        ST_PAUSE: state_s = ST_RUN;
        default:  state_s = ST_IDLE;
      endcase
    end else if (tick_edge_s && (state_r == ST_RUN)) begin
      if (sec_ones_r != 4'd9) begin
        sec_ones_s = sec_ones_r + 4'd1;
      end else begin
        sec_ones_s = 4'd0;
        if (sec_tens_r != 4'd5) begin
          sec_tens_s = sec_tens_r + 4'd1;
        end else begin
          sec_tens_s = 4'd0;
          if ((min_tens_r == MAX_TENS) && (min_ones_r == MAX_ONES)) begin
            min_ones_s = 4'd0;
            min_tens_s = 4'd0;
            wrap_s     = 1'b1;
          end else if (min_ones_r == 4'd9) begin
            min_ones_s = 4'd0;
            min_tens_s = min_tens_r + 4'd1;
          end else begin
            min_ones_s = min_ones_r + 4'd1;
          end
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, live count, edge history and status outputs.
  always_ff @(posedge clk or negedge resetSW) begin
    if (!resetSW) begin
      state_r     <= ST_IDLE;
      tick_prev_r <= 1'b0;
      ss_prev_r   <= 1'b0;
      sec_ones_r  <= 4'd0;
      sec_tens_r  <= 4'd0;
      min_ones_r  <= 4'd0;
      min_tens_r  <= 4'd0;
      running_r   <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      tick_prev_r <= tickIn;
      ss_prev_r   <= startStop;
      sec_ones_r  <= sec_ones_s;
      sec_tens_r  <= sec_tens_s;
      min_ones_r  <= min_ones_s;
      min_tens_r  <= min_tens_s;
      running_r   <= (state_s == ST_RUN);
      wrap_r      <= wrap_s;
    end
  end

  assign running   = running_r;
  assign wrapPulse = wrap_r;

`ifdef STOPWATCH_LAP_EN
  logic       lap_prev_r, lap_hold_r, lap_hold_s, lap_edge_s;
  logic [3:0] disp_so_r, disp_st_r, disp_mo_r, disp_mt_r;

  assign lap_edge_s = lapBtn & ~lap_prev_r;

  // Lap hold toggles only on edges seen in RUN; leaving to IDLE drops it.
  always_comb begin
    lap_hold_s = lap_hold_r;
    if (clear || (state_s == ST_IDLE)) begin
      lap_hold_s = 1'b0;
    end else if (lap_edge_s && (state_r == ST_RUN)) begin
      lap_hold_s = ~lap_hold_r;
    end else begin
      lap_hold_s = lap_hold_r;
    end
  end

  // Display copy follows the live count except while a hold persists.
  always_ff @(posedge clk or negedge resetSW) begin
    if (!resetSW) begin
      lap_prev_r <= 1'b0;
      lap_hold_r <= 1'b0;
      disp_so_r  <= 4'd0;
      disp_st_r  <= 4'd0;
      disp_mo_r  <= 4'd0;
      disp_mt_r  <= 4'd0;
    end else begin
      lap_prev_r <= lapBtn;
      lap_hold_r <= lap_hold_s;
      if (!lap_hold_r || !lap_hold_s) begin
        disp_so_r <= sec_ones_s;
        disp_st_r <= sec_tens_s;
        disp_mo_r <= min_ones_s;
        disp_mt_r <= min_tens_s;
      end else begin
        disp_so_r <= disp_so_r;
        disp_st_r <= disp_st_r;
        disp_mo_r <= disp_mo_r;
        disp_mt_r <= disp_mt_r;
      end
    end
  end

  assign secOnes = disp_so_r;
  assign secTens = disp_st_r;
  assign minOnes = disp_mo_r;
  assign minTens = disp_mt_r;
`else
  logic unused_lap_s;
  assign unused_lap_s = lapBtn;
  assign secOnes = sec_ones_r;
  assign secTens = sec_tens_r;
  assign minOnes = min_ones_r;
  assign minTens = min_tens_r;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: reference model tracks elapsed seconds as an integer.
// Lap scenarios are compiled in when STOPWATCH_LAP_EN is defined.
module tb_bcd_stopwatch;

  localparam int TB_MAX_MIN = 1;
  localparam int PERIOD_S   = (TB_MAX_MIN + 1) * 60;

  logic       clk = 1'b0;
  logic       resetSW, tickIn, startStop, clear, lapBtn;
  logic [3:0] secOnes, secTens, minOnes, minTens;
  logic       running, wrapPulse;
  logic [15:0] disp;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 run, 2 pause; time kept as plain seconds.
  int m_mode, m_secs, m_disp;
  bit m_hold, m_wrap, m_tp, m_sp, m_lp;

  bcd_stopwatch #(.MAX_MIN(TB_MAX_MIN)) dut (
    .clk(clk), .resetSW(resetSW), .tickIn(tickIn), .startStop(startStop),
    .clear(clear), .lapBtn(lapBtn), .secOnes(secOnes), .secTens(secTens),
    .minOnes(minOnes), .minTens(minTens), .running(running), .wrapPulse(wrapPulse)
  );

  always #5 clk = ~clk;
  assign disp = {minTens, minOnes, secTens, secOnes};

  function automatic logic [15:0] digits(int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_disp = 0;
    m_hold = 1'b0; m_wrap = 1'b0; m_tp = 1'b0; m_sp = 1'b0; m_lp = 1'b0;
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then settle.
  task automatic cycle();
    bit te, se, old_hold;
`ifdef STOPWATCH_LAP_EN
    bit le;
    int old_mode;
`endif
    @(posedge clk);
    te = tickIn && !m_tp;
    se = startStop && !m_sp;
`ifdef STOPWATCH_LAP_EN
    le = lapBtn && !m_lp;
    old_mode = m_mode;
`endif
    old_hold = m_hold;
    m_wrap = 1'b0;
    if (clear) begin
      m_mode = 0;
      m_secs = 0;
    end else if (se) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (te && m_mode == 1) begin
      m_secs = m_secs + 1;
      if (m_secs == PERIOD_S) begin
        m_secs = 0;
        m_wrap = 1'b1;
      end
    end
`ifdef STOPWATCH_LAP_EN
    if (le && old_mode == 1 && !clear) m_hold = !m_hold;
`endif
    if (m_mode == 0) m_hold = 1'b0;
    if (!(m_hold && old_hold)) m_disp = m_secs;
    m_tp = tickIn; m_sp = startStop; m_lp = lapBtn;
    #1;
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) begin
      tickIn = 1'b1;
      repeat ($urandom_range(1, 3)) cycle();
      tickIn = 1'b0;
      repeat ($urandom_range(1, 3)) cycle();
    end
  endtask

  task automatic press_ss();
    startStop = 1'b1; cycle();
    startStop = 1'b0; cycle();
  endtask

  task automatic restart();
    clear = 1'b1; cycle();
    clear = 1'b0; cycle();
    press_ss();
  endtask

  task automatic test_reset();
    resetSW = 1'b1; tickIn = 1'b0; startStop = 1'b0; clear = 1'b0; lapBtn = 1'b0;
    #2 resetSW = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({disp, running, wrapPulse} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_async: got %h/%b/%b want 0000/0/0", disp, running, wrapPulse);
    end
    repeat (3) @(posedge clk);
    #1 resetSW = 1'b1;
    cycle();
    n_vec++;
    if ({disp, running, wrapPulse} !== {digits(m_disp), m_mode == 1, m_wrap}) begin
      n_err++;
      $display("FAIL reset_release: got %h/%b/%b want %h/%b/%b", disp, running, wrapPulse,
               digits(m_disp), m_mode == 1, m_wrap);
    end
  endtask

  task automatic test_basic_count();
    restart();
    for (int i = 0; i < 12; i++) begin
      tickIn = 1'b1;
      cycle();
      n_vec++;
      if ({disp, running} !== {digits(m_disp), m_mode == 1}) begin
        n_err++;
        $display("FAIL basic_count_edge%0d: got %h/%b want %h/%b", i, disp, running,
                 digits(m_disp), m_mode == 1);
      end
      repeat ($urandom_range(0, 2)) cycle();
      tickIn = 1'b0;
      repeat ($urandom_range(1, 3)) cycle();
    end
    n_vec++;
    if ({disp, running} !== {16'h0012, 1'b1}) begin
      n_err++;
      $display("FAIL basic_count_final: got %h/%b want 0012/1", disp, running);
    end
  endtask

  task automatic test_pause_resume();
    restart();
    tick_n(5);
    press_ss();
    tick_n(3);
    n_vec++;
    if ({disp, running} !== {digits(m_disp), m_mode == 1}) begin
      n_err++;
      $display("FAIL pause_hold: got %h/%b want %h/%b", disp, running, digits(m_disp), m_mode == 1);
    end
    tickIn = 1'b1; cycle();
    press_ss();
    cycle();
    n_vec++;
    if ({disp, running} !== {digits(m_disp), m_mode == 1}) begin
      n_err++;
      $display("FAIL resume_no_spurious: got %h/%b want %h/%b", disp, running,
               digits(m_disp), m_mode == 1);
    end
    tickIn = 1'b0; cycle();
    tickIn = 1'b1; cycle();
    tickIn = 1'b0; cycle();
    n_vec++;
    if ({disp, running} !== {digits(m_disp), m_mode == 1}) begin
      n_err++;
      $display("FAIL resume_count: got %h/%b want %h/%b", disp, running, digits(m_disp), m_mode == 1);
    end
  endtask

  task automatic test_wrap();
    restart();
    tick_n(PERIOD_S - 1);
    n_vec++;
    if (disp !== digits(m_disp)) begin
      n_err++;
      $display("FAIL wrap_top: got %h want %h", disp, digits(m_disp));
    end
    tickIn = 1'b1; cycle();
    n_vec++;
    if ({disp, running, wrapPulse} !== {digits(m_disp), m_mode == 1, m_wrap}) begin
      n_err++;
      $display("FAIL wrap_edge: got %h/%b/%b want %h/%b/%b", disp, running, wrapPulse,
               digits(m_disp), m_mode == 1, m_wrap);
    end
    tickIn = 1'b0; cycle();
    n_vec++;
    if ({disp, running, wrapPulse} !== {digits(m_disp), m_mode == 1, m_wrap}) begin
      n_err++;
      $display("FAIL wrap_after: got %h/%b/%b want %h/%b/%b", disp, running, wrapPulse,
               digits(m_disp), m_mode == 1, m_wrap);
    end
  endtask

  task automatic test_simultaneous();
    restart();
    tick_n(9);
    startStop = 1'b1; tickIn = 1'b1; clear = 1'b1;
    cycle();
    n_vec++;
    if ({disp, running} !== {digits(m_disp), m_mode == 1}) begin
      n_err++;
      $display("FAIL simul_clear: got %h/%b want %h/%b", disp, running, digits(m_disp), m_mode == 1);
    end
    startStop = 1'b0; tickIn = 1'b0; clear = 1'b0;
    cycle();
    press_ss();
    tick_n(9);
    startStop = 1'b1; tickIn = 1'b1;
    cycle();
    n_vec++;
    if ({disp, running, m_mode} !== {digits(m_disp), 1'b0, 32'd2}) begin
      n_err++;
      $display("FAIL simul_pause: got %h/%b want %h/0", disp, running, digits(m_disp));
    end
    startStop = 1'b0; tickIn = 1'b0;
    cycle();
  endtask

  task automatic test_async_reset();
    restart();
    tick_n(37);
    n_vec++;
    if (disp !== digits(m_disp)) begin
      n_err++;
      $display("FAIL pre_reset_count: got %h want %h", disp, digits(m_disp));
    end
    #2 resetSW = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({disp, running, wrapPulse} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_midcount: got %h/%b/%b want 0000/0/0", disp, running, wrapPulse);
    end
    repeat (2) @(posedge clk);
    #1 resetSW = 1'b1;
    cycle();
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    restart();
    tick_n(10);
    lapBtn = 1'b1; cycle();
    lapBtn = 1'b0; cycle();
    tick_n(5);
    n_vec++;
    if (disp !== digits(m_disp)) begin
      n_err++;
      $display("FAIL lap_freeze: got %h want %h", disp, digits(m_disp));
    end
    lapBtn = 1'b1; cycle();
    n_vec++;
    if (disp !== digits(m_disp)) begin
      n_err++;
      $display("FAIL lap_release: got %h want %h", disp, digits(m_disp));
    end
    lapBtn = 1'b0; cycle();
  endtask
`endif

  task automatic test_random();
    restart();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) tickIn = ~tickIn;
      if ($urandom_range(0, 39) == 0) startStop = ~startStop;
      if ($urandom_range(0, 19) == 0) lapBtn = ~lapBtn;
      clear = ($urandom_range(0, 299) == 0);
      cycle();
      n_vec++;
      if ({disp, running, wrapPulse} !== {digits(m_disp), m_mode == 1, m_wrap}) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h/%b/%b want %h/%b/%b", i, disp, running, wrapPulse,
                 digits(m_disp), m_mode == 1, m_wrap);
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_wrap();
    test_simultaneous();
    test_async_reset();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
